// File: rtl/run_controller.sv
// Run sequencer and DataRAM arbiter for the single-cycle core: host load/readback,
// one-cycle core init pulse, halt detection, cycle counting and watchdog abort.
module run_controller #(
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        start,
  input  logic        go,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic        core_init,
  input  logic        core_halt,
  input  logic [7:0]  core_addr,
  input  logic        core_we,
  input  logic [7:0]  core_wdata,
  output logic [7:0]  core_rdata,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] run_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cycles;
  logic        r_timeout;
  logic        r_ack;
  logic [7:0]  r_rdata;

  logic        w_host_own;
  logic        w_accept;
  logic        w_wd_hit;
  logic        w_enter_init;
  logic        w_end_run;
  logic        w_count;

  always_comb begin
    w_host_own   = (r_state == S_IDLE) || (r_state == S_DONE);
    w_accept     = w_host_own && host_req;
    w_wd_hit     = (r_cycles == MAX_CYCLES);
    w_enter_init = w_host_own && go;
    // halt takes priority over the watchdog when both land on the same edge
    w_end_run    = (r_state == S_RUN) && (core_halt || w_wd_hit);
    w_count      = (r_state == S_RUN) && !core_halt && (r_cycles < MAX_CYCLES);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (go) w_next = S_INIT;
      S_INIT:  w_next = S_RUN;
      S_RUN:   if (core_halt || w_wd_hit) w_next = S_DONE;
      S_DONE:  if (go) w_next = S_INIT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge start) begin
    if (start) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      r_cycles  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_enter_init)  r_cycles <= '0;
      else if (w_count)  r_cycles <= r_cycles + 16'd1;

      if (w_enter_init)   r_timeout <= 1'b0;
      else if (w_end_run) r_timeout <= !core_halt;
    end
  end

  // Host read data is captured at the accept edge so the ack lands one cycle later.
  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_accept;
      if (w_accept) r_rdata <= mem_rdata;
    end
  end

  always_comb begin
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    mem_we    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: mem_we = host_req && host_we;
      S_INIT: begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      S_RUN: begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_we    = core_we;
      end
      default: mem_we = 1'b0;
    endcase
  end

  assign core_rdata = mem_rdata;
  assign core_init  = (r_state == S_INIT);
  assign busy       = (r_state == S_INIT) || (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign timeout    = r_timeout;
  assign run_cycles = r_cycles;
  assign host_ack   = r_ack;
  assign host_rdata = r_rdata;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller with a behavioural DataRAM and a host-ack scoreboard.
module tb_run_controller;

  logic        CLK;
  logic        start;
  logic        go;
  logic        host_req;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        core_init;
  logic        core_halt;
  logic [7:0]  core_addr;
  logic        core_we;
  logic [7:0]  core_wdata;
  logic [7:0]  core_rdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] run_cycles;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       is_rd;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  logic [7:0] ram [256];

  run_controller #(.MAX_CYCLES(16'd8)) dut (
    .CLK(CLK), .start(start), .go(go),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .core_init(core_init), .core_halt(core_halt), .core_addr(core_addr),
    .core_we(core_we), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .timeout(timeout),
    .run_cycles(run_cycles)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  assign mem_rdata = ram[mem_addr];
  always @(posedge CLK) if (mem_we) ram[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Acks are popped against the scoreboard; read acks also carry data.
  always @(negedge CLK) begin
    if (host_ack) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_rd) chk("host_rdata", {24'd0, host_rdata}, {24'd0, e.data});
      end
    end
  end

  // Entered in the INIT cycle; returns counts of busy, init and RUN cycles seen before DONE.
  task automatic run_core(input int halt_at, output int nb, output int ni, output int nr);
    nb = 0; ni = 0; nr = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) break;
      if (busy) nb++;
      if (core_init) ni++;
      else if (busy) nr++;
      core_halt = (halt_at != 0) && (nr == halt_at) && !core_init;
      tick();
    end
    core_halt = 1'b0;
    chk("run_reached_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int nb, ni, nr;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    start = 1'b1; go = 1'b0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0; core_halt = 1'b0;
    core_addr = '0; core_we = 1'b0; core_wdata = '0;
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_init", {31'd0, core_init}, 32'd0);
    chk("rst_cycles", {16'd0, run_cycles}, 32'd0);
    chk("rst_ack", {31'd0, host_ack}, 32'd0);
    start = 1'b0;
    tick();

    // Host write then read in IDLE
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h3C;
    sb.push_back('{1'b0, 8'h00});
    #1 chk("idle_host_we", {31'd0, mem_we}, 32'd1);
    tick();
    chk("wr_ack", {31'd0, host_ack}, 32'd1);
    host_we = 1'b0;
    sb.push_back('{1'b1, 8'h3C});
    tick();
    host_req = 1'b0;
    chk("rd_ack", {31'd0, host_ack}, 32'd1);
    chk("rd_data", {24'd0, host_rdata}, 32'h3C);
    tick();
    chk("ack_drop", {31'd0, host_ack}, 32'd0);

    // Run with halt on the 5th RUN cycle
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("init_cycles0", {16'd0, run_cycles}, 32'd0);
    run_core(5, nb, ni, nr);
    chk("halt_busy", nb, 6);
    chk("halt_init", ni, 1);
    chk("halt_run", nr, 5);
    chk("halt_cycles", {16'd0, run_cycles}, 32'd4);
    chk("halt_timeout", {31'd0, timeout}, 32'd0);

    // Host request held across a run while the core writes
    go = 1'b1;
    tick();
    go = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h50;
    core_we = 1'b1; core_addr = 8'h33; core_wdata = 8'hEE;
    #1;
    chk("init_mem_we", {31'd0, mem_we}, 32'd0);
    chk("init_mem_addr", {24'd0, mem_addr}, 32'h33);
    core_we = 1'b0;
    tick();
    chk("run1_no_ack", {31'd0, host_ack}, 32'd0);
    core_we = 1'b1; core_addr = 8'h40; core_wdata = 8'h77;
    #1;
    chk("run_mem_we", {31'd0, mem_we}, 32'd1);
    chk("run_mem_addr", {24'd0, mem_addr}, 32'h40);
    chk("run_mem_wdata", {24'd0, mem_wdata}, 32'h77);
    chk("run_core_rdata", {24'd0, core_rdata}, 32'h40 ^ 32'hA5);
    tick();
    core_we = 1'b0;
    chk("run2_no_ack", {31'd0, host_ack}, 32'd0);
    tick();
    chk("run3_no_ack", {31'd0, host_ack}, 32'd0);
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    chk("held_done", {31'd0, done}, 32'd1);
    chk("done_entry_no_ack", {31'd0, host_ack}, 32'd0);
    sb.push_back('{1'b1, 8'hF5});
    tick();
    chk("held_first_ack", {31'd0, host_ack}, 32'd1);
    host_addr = 8'h40;
    sb.push_back('{1'b1, 8'h77});
    tick();
    host_req = 1'b0;
    chk("held_second_ack", {31'd0, host_ack}, 32'd1);
    tick();
    chk("held_ack_drop", {31'd0, host_ack}, 32'd0);

    // Watchdog on a core that never halts
    go = 1'b1;
    tick();
    go = 1'b0;
    run_core(0, nb, ni, nr);
    chk("wd_busy", nb, 10);
    chk("wd_run", nr, 9);
    chk("wd_cycles", {16'd0, run_cycles}, 32'd8);
    chk("wd_timeout", {31'd0, timeout}, 32'd1);

    // Halt and watchdog on the same edge: halt wins
    go = 1'b1;
    tick();
    go = 1'b0;
    run_core(9, nb, ni, nr);
    chk("tie_cycles", {16'd0, run_cycles}, 32'd8);
    chk("tie_timeout", {31'd0, timeout}, 32'd0);
    go = 1'b1;
    tick();
    go = 1'b0;
    run_core(0, nb, ni, nr);
    chk("wd2_timeout", {31'd0, timeout}, 32'd1);

    // go with a host read in DONE
    go = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    sb.push_back('{1'b1, 8'h85});
    tick();
    go = 1'b0; host_req = 1'b0;
    chk("go_rd_init", {31'd0, core_init}, 32'd1);
    chk("go_rd_ack", {31'd0, host_ack}, 32'd1);
    chk("go_rd_data", {24'd0, host_rdata}, 32'h85);
    chk("go_rd_cycles", {16'd0, run_cycles}, 32'd0);
    chk("go_rd_timeout", {31'd0, timeout}, 32'd0);

    // Reset mid-RUN with a core write in flight
    tick();
    tick();
    core_we = 1'b1; core_addr = 8'h60; core_wdata = 8'h99;
    #1 chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
    start = 1'b1;
    #1;
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_init", {31'd0, core_init}, 32'd0);
    chk("mid_rst_cycles", {16'd0, run_cycles}, 32'd0);
    chk("mid_rst_ack", {31'd0, host_ack}, 32'd0);
    chk("mid_rst_rdata", {24'd0, host_rdata}, 32'd0);
    tick();
    tick();
    start = 1'b0; core_we = 1'b0;
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h60;
    sb.push_back('{1'b1, 8'hC5});
    tick();
    host_req = 1'b0;
    chk("post_rst_ack", {31'd0, host_ack}, 32'd1);
    tick();
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
